id_exe_reg: RTL and testbench
=============================

# id_exe_reg

ID/EX pipeline register of the five-stage ARM-subset core. Captures the decoded control word produced by the control unit (exe_cmd, MEM_R_EN, MEM_W_EN, WB_EN, B, S) together with operands and register indices, and presents them to the EXE stage one cycle later. Supports stall (freeze), bubble insertion for hazards, and flush on a taken branch. Keeps two saturating debug counters for flushes and stall cycles.

## Interface
- WORD_WIDTH, 32, width of PC and operand values
- REG_ADDR_WIDTH, 4, width of register indices
- CNT_WIDTH, 16, width of the debug counters
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- freeze  in  1  hold all contents (memory/stage stall)
- bubble  in  1  hazard detected; load a NOP instead of ID contents
- flush  in  1  branch taken in EXE; discard the ID instruction
- exe_cmd_in  in  4  ALU command from the control unit
- mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in  in  1 each  control bits from the control unit
- carry_in  in  1  C flag from the status register, sampled for ADC/SBC
- pc_in  in  WORD_WIDTH  PC+4 of the ID instruction
- val_rn_in, val_rm_in  in  WORD_WIDTH  register file read values
- imm_in  in  1  I bit
- shift_operand_in  in  12  shifter operand field
- signed_imm_24_in  in  24  branch offset
- dest_in, src1_in, src2_in  in  REG_ADDR_WIDTH  destination and source indices
- All *_in above have a same-named *_out (registered, identical width)
- valid_out  out  1  EXE holds a real instruction
- flush_cnt  out  CNT_WIDTH  cycles in which a flush was applied
- stall_cnt  out  CNT_WIDTH  cycles in which freeze or bubble was active

## Operation
- Per-edge priority: reset > flush > freeze > bubble > load.
- Reset (rst_n low, async): every output 0, including valid_out and both counters. Takes effect immediately, not at the next edge.
- Flush: load the NOP word and set valid_out=0.
  - NOP word: exe_cmd_out=0, all enables 0, all data and index fields 0.
  - Flush overrides a simultaneous freeze: a wrong-path instruction is never held.
- Freeze (flush=0): all outputs, including valid_out, hold their previous values.
  - bubble is ignored while freeze is high.
- Bubble (flush=0, freeze=0): load the NOP word, valid_out=0.
- Load (no control asserted): capture every *_in into *_out, valid_out=1.
  - A load with all-zero control bits is still valid; that is how B-type and CMP/TST encodings flow.
- flush_cnt: +1 on each edge where flush=1 and rst_n=1.
- stall_cnt: +1 on each edge where (freeze | bubble)=1 and flush=0.
- Both counters saturate at all-ones and do not wrap.
- No combinational path from any input to any output.

## Timing
- Latency: exactly 1 cycle from ID inputs to *_out.
- Flush and bubble take effect at the same edge on which they are sampled high; the NOP is visible in the cycle after that edge.
- Back-to-back freezes hold for their full duration. The first non-freeze edge resumes normal priority and loads, bubbles, or flushes based on current inputs.
- Reset deassertion is synchronised externally. The first edge with rst_n high performs a normal load.

## Test plan
- Reset mid-operation: load ADD (exe_cmd=4'b0010, wb_en=1, dest=3), then pull rst_n low between edges. All outputs read 0 before the next edge; counters read 0.
- Plain load: ID presents LDR (mem_r_en=1, wb_en=1, s=1, val_rn=32'h0000_0100, dest=5). Next cycle the outputs match exactly and valid_out=1.
- Freeze hold: load SUB, then freeze=1 for 3 cycles while the inputs change to random values. Outputs stay SUB with valid_out=1; stall_cnt=3.
- Flush beats freeze: freeze=1 and flush=1 on the same edge with STR loaded. Outputs become the NOP word with valid_out=0; flush_cnt=1 and stall_cnt unchanged.
- Bubble: bubble=1 with MOV on the inputs. NOP loaded, valid_out=0. The following cycle (bubble=0) MOV appears with valid_out=1.
- Counter saturation: force stall_cnt to 16'hFFFE and hold freeze 3 more cycles. stall_cnt reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/id_exe_reg.sv
// ID/EX pipeline register for the five-stage ARM-subset core.
// Holds the decoded control word, operands and register indices of the ID stage
// and presents them to EXE one cycle later.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   freeze, bubble, flush           hold / insert NOP / discard (flush > freeze > bubble)
//   *_in                            ID-stage control, operands, indices
//   *_out                           registered copies presented to EXE
//   valid_out                       EXE holds a real instruction
//   flush_cnt, stall_cnt            saturating debug counters
module id_exe_reg #(
    parameter int unsigned WORD_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 4,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      freeze,
    input  logic                      bubble,
    input  logic                      flush,
    input  logic [3:0]                exe_cmd_in,
    input  logic                      mem_r_en_in,
    input  logic                      mem_w_en_in,
    input  logic                      wb_en_in,
    input  logic                      b_in,
    input  logic                      s_in,
    input  logic                      carry_in,
    input  logic [WORD_WIDTH-1:0]     pc_in,
    input  logic [WORD_WIDTH-1:0]     val_rn_in,
    input  logic [WORD_WIDTH-1:0]     val_rm_in,
    input  logic                      imm_in,
    input  logic [11:0]               shift_operand_in,
    input  logic [23:0]               signed_imm_24_in,
    input  logic [REG_ADDR_WIDTH-1:0] dest_in,
    input  logic [REG_ADDR_WIDTH-1:0] src1_in,
    input  logic [REG_ADDR_WIDTH-1:0] src2_in,
    output logic [3:0]                exe_cmd_out,
    output logic                      mem_r_en_out,
    output logic                      mem_w_en_out,
    output logic                      wb_en_out,
    output logic                      b_out,
    output logic                      s_out,
    output logic                      carry_out,
    output logic [WORD_WIDTH-1:0]     pc_out,
    output logic [WORD_WIDTH-1:0]     val_rn_out,
    output logic [WORD_WIDTH-1:0]     val_rm_out,
    output logic                      imm_out,
    output logic [11:0]               shift_operand_out,
    output logic [23:0]               signed_imm_24_out,
    output logic [REG_ADDR_WIDTH-1:0] dest_out,
    output logic [REG_ADDR_WIDTH-1:0] src1_out,
    output logic [REG_ADDR_WIDTH-1:0] src2_out,
    output logic                      valid_out,
    output logic [CNT_WIDTH-1:0]      flush_cnt,
    output logic [CNT_WIDTH-1:0]      stall_cnt
);

    // Stage payload; the all-zero value is the NOP word.
    typedef struct packed {
        logic [3:0]                exe_cmd;
        logic                      mem_r_en;
        logic                      mem_w_en;
        logic                      wb_en;
        logic                      b;
        logic                      s;
        logic                      carry;
        logic [WORD_WIDTH-1:0]     pc;
        logic [WORD_WIDTH-1:0]     val_rn;
        logic [WORD_WIDTH-1:0]     val_rm;
        logic                      imm;
        logic [11:0]               shift_operand;
        logic [23:0]               signed_imm_24;
        logic [REG_ADDR_WIDTH-1:0] dest;
        logic [REG_ADDR_WIDTH-1:0] src1;
        logic [REG_ADDR_WIDTH-1:0] src2;
    } id_ex_t;

    id_ex_t                r_pl;
    logic                  r_valid;
    logic [CNT_WIDTH-1:0]  r_flush_cnt;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;

    id_ex_t                w_id;
    id_ex_t                w_next_pl;
    logic                  w_next_valid;
    logic                  w_stall_inc;

    // Gather ID inputs and resolve flush > freeze > bubble > load.
    always_comb begin
        w_id = '{exe_cmd:       exe_cmd_in,
                 mem_r_en:      mem_r_en_in,
                 mem_w_en:      mem_w_en_in,
                 wb_en:         wb_en_in,
                 b:             b_in,
                 s:             s_in,
                 carry:         carry_in,
                 pc:            pc_in,
                 val_rn:        val_rn_in,
                 val_rm:        val_rm_in,
                 imm:           imm_in,
                 shift_operand: shift_operand_in,
                 signed_imm_24: signed_imm_24_in,
                 dest:          dest_in,
                 src1:          src1_in,
                 src2:          src2_in};
        w_next_pl    = r_pl;
        w_next_valid = r_valid;
        if (flush) begin
            w_next_pl    = '0;
            w_next_valid = 1'b0;
        end else if (!freeze) begin
            if (bubble) begin
                w_next_pl    = '0;
                w_next_valid = 1'b0;
            end else begin
                w_next_pl    = w_id;
                w_next_valid = 1'b1;
            end
        end
    end

    // A flush cycle is not counted as a stall even if freeze/bubble are high.
    assign w_stall_inc = (freeze | bubble) & ~flush;

    // Pipeline register and saturating debug counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pl        <= '0;
            r_valid     <= 1'b0;
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_pl    <= w_next_pl;
            r_valid <= w_next_valid;
            if (flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
            end
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign exe_cmd_out       = r_pl.exe_cmd;
    assign mem_r_en_out      = r_pl.mem_r_en;
    assign mem_w_en_out      = r_pl.mem_w_en;
    assign wb_en_out         = r_pl.wb_en;
    assign b_out             = r_pl.b;
    assign s_out             = r_pl.s;
    assign carry_out         = r_pl.carry;
    assign pc_out            = r_pl.pc;
    assign val_rn_out        = r_pl.val_rn;
    assign val_rm_out        = r_pl.val_rm;
    assign imm_out           = r_pl.imm;
    assign shift_operand_out = r_pl.shift_operand;
    assign signed_imm_24_out = r_pl.signed_imm_24;
    assign dest_out          = r_pl.dest;
    assign src1_out          = r_pl.src1;
    assign src2_out          = r_pl.src2;
    assign valid_out         = r_valid;
    assign flush_cnt         = r_flush_cnt;
    assign stall_cnt         = r_stall_cnt;

endmodule

// File: tb/tb_id_exe_reg.sv
// Self-checking bench for id_exe_reg: directed table, reset/saturation
// sequences and randomized traffic against a behavioural model.
module tb_id_exe_reg;

    typedef struct packed {
        logic [3:0]  exe_cmd;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        wb_en;
        logic        b;
        logic        s;
        logic        carry;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
    } payload_t;

    typedef struct {
        bit       flush;
        bit       freeze;
        bit       bubble;
        payload_t in;
        bit       exp_valid;
        payload_t exp_pl;
        int       exp_stall;
        int       exp_flush;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        freeze, bubble, flush;
    logic [3:0]  exe_cmd_in, exe_cmd_out;
    logic        mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, carry_in, imm_in;
    logic        mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, carry_out, imm_out;
    logic [31:0] pc_in, val_rn_in, val_rm_in, pc_out, val_rn_out, val_rm_out;
    logic [11:0] shift_operand_in, shift_operand_out;
    logic [23:0] signed_imm_24_in, signed_imm_24_out;
    logic [3:0]  dest_in, src1_in, src2_in, dest_out, src1_out, src2_out;
    logic        valid_out;
    logic [15:0] flush_cnt, stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    id_exe_reg #(.WORD_WIDTH(32), .REG_ADDR_WIDTH(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .bubble(bubble), .flush(flush),
        .exe_cmd_in(exe_cmd_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .wb_en_in(wb_en_in), .b_in(b_in), .s_in(s_in), .carry_in(carry_in),
        .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
        .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
        .exe_cmd_out(exe_cmd_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .wb_en_out(wb_en_out), .b_out(b_out), .s_out(s_out), .carry_out(carry_out),
        .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .imm_out(imm_out),
        .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
        .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out),
        .valid_out(valid_out), .flush_cnt(flush_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic payload_t mk(input logic [3:0] cmd, input bit mr, input bit mw,
                                    input bit wb, input bit bb, input bit ss,
                                    input logic [31:0] rn, input logic [3:0] dst);
        payload_t p;
        p = '0;
        p.exe_cmd = cmd; p.mem_r_en = mr; p.mem_w_en = mw; p.wb_en = wb;
        p.b = bb; p.s = ss; p.val_rn = rn; p.dest = dst;
        p.pc = 32'h0000_1000 + 32'(dst) * 32'd4;
        p.val_rm = 32'hA5A5_0000 | 32'(cmd);
        p.shift_operand = 12'h0F0;
        p.src1 = 4'd1; p.src2 = 4'd2;
        return p;
    endfunction

    function automatic payload_t rnd_payload();
        payload_t p;
        p.exe_cmd = 4'($urandom); p.mem_r_en = 1'($urandom); p.mem_w_en = 1'($urandom);
        p.wb_en = 1'($urandom); p.b = 1'($urandom); p.s = 1'($urandom);
        p.carry = 1'($urandom); p.pc = $urandom; p.val_rn = $urandom; p.val_rm = $urandom;
        p.imm = 1'($urandom); p.shift_operand = 12'($urandom);
        p.signed_imm_24 = 24'($urandom); p.dest = 4'($urandom);
        p.src1 = 4'($urandom); p.src2 = 4'($urandom);
        return p;
    endfunction

    task automatic drive(input bit fl, input bit fr, input bit bu, input payload_t p);
        flush = fl; freeze = fr; bubble = bu;
        exe_cmd_in = p.exe_cmd; mem_r_en_in = p.mem_r_en; mem_w_en_in = p.mem_w_en;
        wb_en_in = p.wb_en; b_in = p.b; s_in = p.s; carry_in = p.carry;
        pc_in = p.pc; val_rn_in = p.val_rn; val_rm_in = p.val_rm; imm_in = p.imm;
        shift_operand_in = p.shift_operand; signed_imm_24_in = p.signed_imm_24;
        dest_in = p.dest; src1_in = p.src1; src2_in = p.src2;
    endtask

    function automatic payload_t outs();
        payload_t p;
        p.exe_cmd = exe_cmd_out; p.mem_r_en = mem_r_en_out; p.mem_w_en = mem_w_en_out;
        p.wb_en = wb_en_out; p.b = b_out; p.s = s_out; p.carry = carry_out;
        p.pc = pc_out; p.val_rn = val_rn_out; p.val_rm = val_rm_out; p.imm = imm_out;
        p.shift_operand = shift_operand_out; p.signed_imm_24 = signed_imm_24_out;
        p.dest = dest_out; p.src1 = src1_out; p.src2 = src2_out;
        return p;
    endfunction

    task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_pl(input string name, input payload_t exp);
        payload_t act;
        act = outs();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    payload_t ADD, LDR, SUB, STR, MOV, ZCTL, NOP;
    vec_t     vecs[11];

    payload_t m_pl;
    bit       m_valid;
    int       m_stall, m_flush;

    initial begin
        ADD  = mk(4'b0010, 0, 0, 1, 0, 0, 32'h0000_0011, 4'd3);
        LDR  = mk(4'b0010, 1, 0, 1, 0, 1, 32'h0000_0100, 4'd5);
        SUB  = mk(4'b0100, 0, 0, 1, 0, 1, 32'h0000_0222, 4'd6);
        STR  = mk(4'b0010, 0, 1, 0, 0, 0, 32'h0000_0333, 4'd7);
        MOV  = mk(4'b0001, 0, 0, 1, 0, 0, 32'h0000_0444, 4'd8);
        ZCTL = mk(4'b0000, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 4'd9);
        ZCTL.signed_imm_24 = 24'h12_3456;
        NOP  = '0;

        // {flush, freeze, bubble, inputs, exp_valid, exp_payload, exp_stall, exp_flush}
        vecs[0]  = '{0, 0, 0, LDR,  1, LDR,  0, 0};
        vecs[1]  = '{0, 0, 0, SUB,  1, SUB,  0, 0};
        vecs[2]  = '{0, 1, 0, ADD,  1, SUB,  1, 0};
        vecs[3]  = '{0, 1, 0, MOV,  1, SUB,  2, 0};
        vecs[4]  = '{0, 1, 1, LDR,  1, SUB,  3, 0};
        vecs[5]  = '{0, 0, 0, STR,  1, STR,  3, 0};
        vecs[6]  = '{1, 1, 0, MOV,  0, NOP,  3, 1};
        vecs[7]  = '{0, 0, 1, MOV,  0, NOP,  4, 1};
        vecs[8]  = '{0, 0, 0, MOV,  1, MOV,  4, 1};
        vecs[9]  = '{1, 0, 1, ADD,  0, NOP,  4, 2};
        vecs[10] = '{0, 0, 0, ZCTL, 1, ZCTL, 4, 2};

        // Reset state
        rst_n = 1'b0;
        drive(0, 0, 0, NOP);
        #2;
        check_pl("reset_payload", NOP);
        check_v("reset_valid", 32'(valid_out), 32'd0);
        check_v("reset_cnts", {flush_cnt, stall_cnt}, 32'd0);
        #10;
        rst_n = 1'b1;

        // Load ADD, then async reset between edges
        drive(0, 0, 0, ADD);
        step();
        check_pl("add_load", ADD);
        check_v("add_valid", 32'(valid_out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_pl("async_rst_payload", NOP);
        check_v("async_rst_valid", 32'(valid_out), 32'd0);
        check_v("async_rst_cnts", {flush_cnt, stall_cnt}, 32'd0);
        #2 rst_n = 1'b1;
        drive(0, 0, 0, NOP);
        step();
        check_v("first_edge_valid", 32'(valid_out), 32'd1);

        // Directed table
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].flush, vecs[i].freeze, vecs[i].bubble, vecs[i].in);
            step();
            check_pl($sformatf("vec%0d_payload", i), vecs[i].exp_pl);
            check_v($sformatf("vec%0d_valid", i), 32'(valid_out), 32'(vecs[i].exp_valid));
            check_v($sformatf("vec%0d_stall", i), 32'(stall_cnt), 32'(vecs[i].exp_stall));
            check_v($sformatf("vec%0d_flush", i), 32'(flush_cnt), 32'(vecs[i].exp_flush));
        end

        // Freeze with random inputs for 3 cycles holds SUB
        drive(0, 0, 0, SUB);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, rnd_payload());
            step();
            check_pl("freeze_rand_hold", SUB);
            check_v("freeze_rand_valid", 32'(valid_out), 32'd1);
        end
        check_v("freeze_rand_stall", 32'(stall_cnt), 32'd7);

        // Randomized traffic against the model
        m_pl = SUB; m_valid = 1'b1; m_stall = 7; m_flush = 2;
        for (int c = 0; c < 300; c++) begin
            bit fl, fr, bu;
            payload_t p;
            fl = ($urandom_range(7) == 0);
            fr = ($urandom_range(3) == 0);
            bu = ($urandom_range(5) == 0);
            p  = rnd_payload();
            drive(fl, fr, bu, p);
            if (fl) begin
                m_pl = '0; m_valid = 1'b0;
                m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
            end else if (fr || bu) begin
                m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
                if (!fr) begin
                    m_pl = '0; m_valid = 1'b0;
                end
            end else begin
                m_pl = p; m_valid = 1'b1;
            end
            step();
            check_pl("rand_payload", m_pl);
            check_v("rand_valid", 32'(valid_out), 32'(m_valid));
            check_v("rand_stall", 32'(stall_cnt), 32'(m_stall));
            check_v("rand_flush", 32'(flush_cnt), 32'(m_flush));
        end

        // Stall counter saturation
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        drive(0, 1, 0, MOV);
        repeat (65534) @(posedge clk);
        #1;
        check_v("stall_fffe", 32'(stall_cnt), 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            step();
            check_v("stall_sat", 32'(stall_cnt), 32'h0000_FFFF);
        end
        check_v("sat_hold_valid", 32'(valid_out), 32'd0);
        check_v("sat_flush_cnt", 32'(flush_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
